irq_pic: RTL
============

# irq_pic

Eight-input priority interrupt controller sitting directly downstream of the IRQ test block and the on-board peripherals: it edge-detects request lines, including the 7-bit test IRQ outputs, and latches them into a request register. It resolves fixed priority against a mask and an in-service register, then presents `intr` plus an 8-bit vector to the CPU core through a single-cycle `inta` handshake. Software programs the mask and vector base and issues end-of-interrupt commands over the 16-bit data bus, with the same cs/access/ack protocol as the other memory-mapped peripherals.

## Interface
- No parameters.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `cs` input 1: chip select for this block's register window.
- `data_m_addr` input 1: word select, 0 = MASK/BASE, 1 = IRR/ISR/EOI.
- `data_m_data_in` input 16: write data.
- `data_m_bytesel` input 2: byte enables; [0] = low byte, [1] = high byte.
- `data_m_data_out` output 16: read data, registered.
- `data_m_wr_en` input 1: 1 = write, 0 = read.
- `data_m_access` input 1: bus access strobe.
- `data_m_ack` output 1: access acknowledge.
- `irqs` input 8: asynchronous request lines; bit 0 has the highest priority.
- `intr` output 1: interrupt request to the CPU.
- `inta` input 1: one-cycle interrupt acknowledge from the CPU.
- `irq_vector` output 8: vector latched on `inta`.

## Operation
- Registers:
  - IMR[7:0]: 1 = masked.
  - BASE[7:3]: vector base.
  - IRR[7:0]: pending requests.
  - ISR[7:0]: requests in service.
- Word 0:
  - Read returns {BASE,3'b0, IMR}.
  - Write: bytesel[0] loads IMR from data[7:0]; bytesel[1] loads BASE from data[15:11]; data[10:8] are ignored.
- Word 1:
  - Read returns {ISR, IRR}.
  - Write with bytesel[0] is a non-specific EOI: it clears the lowest-numbered set ISR bit, and the data value is ignored. With ISR = 0 it has no effect.
  - Writes to the high byte are ignored.
- Input path: each `irqs` bit passes through 2 synchronizer flops plus a history flop. A synchronized rising edge sets the corresponding IRR bit. Levels are ignored.
- Eligible set is IRR & ~IMR. The winner is the lowest-numbered eligible bit whose index is strictly below the lowest set ISR bit (fully nested); with ISR = 0, any eligible bit qualifies.
- `intr` is registered and is 1 iff a winner exists.
- On `inta`:
  - If a winner exists: clear IRR[w], set ISR[w], and set `irq_vector` = {BASE, w[2:0]}.
  - If no winner exists (spurious): `irq_vector` = {BASE, 3'd7}; IRR and ISR are unchanged.
- Masking does not clear IRR. A masked request pends until it is unmasked.
- Simultaneous events:
  - New edge on bit w in the same cycle as `inta` clearing IRR[w]: the set wins and IRR[w] stays 1.
  - EOI write in the same cycle as `inta`: the EOI target is chosen from ISR before the `inta` update. Both updates apply.
  - IMR write in the same cycle as `inta`: the winner is computed with the old IMR.
- Reset values:
  - IMR = 8'hFF, BASE = 5'b00001 (vector 0x08).
  - IRR = 0, ISR = 0.
  - Synchronizer and history flops = 0.
  - `intr` = 0, `irq_vector` = 0, `data_m_ack` = 0, `data_m_data_out` = 0.
- Reset asserted mid-handshake clears everything immediately. An `inta` that arrives while `reset` is high is ignored.

## Timing
- `data_m_ack` rises one cycle after `cs & data_m_access` and is high for exactly one cycle per access cycle.
- `data_m_data_out` is valid in the same cycle as `data_m_ack`. It is 16'h0 when the access is not a read.
- Register writes take effect at the edge where `data_m_access & cs & data_m_wr_en` is sampled.
- Edge latency: an `irqs` rising edge is sampled at E0, IRR is set at E2, and `intr` rises at E3.
- `irq_vector` is valid from the cycle after `inta`. It holds until the next `inta` or reset.
- `intr` is re-evaluated every cycle. After `inta`, it drops one cycle later unless another higher-priority eligible request remains. Bus writes to IMR and EOI likewise affect `intr` one cycle later.
- `inta` is a single-cycle pulse. A multi-cycle `inta` is treated as one acknowledge per high cycle.

## Test plan
- **Reset defaults:** after reset, read word 0 -> 16'h08FF; read word 1 -> 16'h0000; `intr` = 0.
- **Single request:**
  - Stimulus: write IMR = 8'hFE, pulse irqs[0].
  - Required: `intr` rises 3 cycles after the sampled edge.
  - Then pulse `inta` -> `irq_vector` = 8'h08, IRR = 0, ISR = 8'h01, `intr` = 0.
  - Then write EOI -> ISR = 0.
- **Priority and nesting:**
  - Stimulus: BASE = 0x20, IMR = 0, irqs[3] and irqs[5] edge together.
  - Required: `inta` -> vector 0x23. A second `inta` before EOI -> spurious 0x27 with IRR[5] still set. EOI then `inta` -> 0x25.
  - Then irqs[1] edge while ISR = 8'h20 -> `intr` asserts (nests above bit 5).
- **Masking:** IMR = 8'hFF, edge on irqs[2] -> `intr` stays 0 and IRR = 8'h04. Write IMR = 8'hFB -> `intr` = 1 one cycle later.
- **Simultaneous events:**
  - Edge on irqs[4] landing in IRR in the same cycle that `inta` services bit 4 -> IRR[4] remains 1 and ISR[4] = 1.
  - EOI and `inta` in the same cycle with ISR = 8'h02 and pending bit 0 -> ISR = 8'h01.
- **Reset mid-operation:** with `intr` = 1 and ISR nonzero, assert `reset` asynchronously -> all outputs and registers return to reset values before the next clock edge.

Source files
------------

// File: rtl/irq_pic.sv
// -----------------------------------------------------------------------------
// irq_pic -- eight-input fixed-priority interrupt controller
//
// Request lines are synchronised (two flops), edge-detected against a history
// flop and latched into IRR. The winner is the lowest-numbered bit of
// IRR & ~IMR that sits strictly above (numerically below) the lowest in-service
// bit, giving fully nested operation. The CPU sees a registered `intr` and
// acknowledges with a one-cycle `inta`, after which `irq_vector` holds
// {BASE, winner} (or {BASE, 3'd7} for a spurious acknowledge).
//
// Ports
//   clk              system clock
//   reset            asynchronous, active-high reset
//   cs               chip select for the register window
//   data_m_addr      word select: 0 = MASK/BASE, 1 = IRR/ISR/EOI
//   data_m_data_in   16-bit write data
//   data_m_bytesel   byte enables, [0] low byte, [1] high byte
//   data_m_data_out  registered read data (0 when the access is not a read)
//   data_m_wr_en     1 = write, 0 = read
//   data_m_access    bus access strobe
//   data_m_ack       one-cycle access acknowledge
//   irqs             asynchronous request lines, bit 0 highest priority
//   intr             registered interrupt request to the CPU
//   inta             one-cycle interrupt acknowledge from the CPU
//   irq_vector       vector latched on inta
// -----------------------------------------------------------------------------
module irq_pic (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        data_m_addr,
    input  logic [15:0] data_m_data_in,
    input  logic [1:0]  data_m_bytesel,
    output logic [15:0] data_m_data_out,
    input  logic        data_m_wr_en,
    input  logic        data_m_access,
    output logic        data_m_ack,
    input  logic [7:0]  irqs,
    output logic        intr,
    input  logic        inta,
    output logic [7:0]  irq_vector
);

    // Isolate the lowest set bit of a byte (two's-complement trick).
    function automatic logic [7:0] lowest_one(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    // Encode a one-hot byte into its bit index; zero encodes as 0.
    function automatic logic [2:0] encode8(input logic [7:0] onehot);
        logic [2:0] idx;
        case (onehot)
            8'h01:   idx = 3'd0;
            8'h02:   idx = 3'd1;
            8'h04:   idx = 3'd2;
            8'h08:   idx = 3'd3;
            8'h10:   idx = 3'd4;
            8'h20:   idx = 3'd5;
            8'h40:   idx = 3'd6;
            8'h80:   idx = 3'd7;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [7:0]  sync1_r;
    logic [7:0]  sync2_r;
    logic [7:0]  hist_r;
    logic [7:0]  irr_r;
    logic [7:0]  isr_r;
    logic [7:0]  imr_r;
    logic [4:0]  base_r;
    logic        intr_r;
    logic        ack_r;
    logic [15:0] rdata_r;
    logic [7:0]  vector_r;

    // ---------------------------------------------------------------------
    // Combinational decode
    // ---------------------------------------------------------------------
    logic [7:0]  rise_s;
    logic [7:0]  eligible_s;
    logic [7:0]  isr_low_s;
    logic [7:0]  nest_mask_s;
    logic [7:0]  cand_s;
    logic [7:0]  grant_s;
    logic [2:0]  win_idx_s;
    logic        win_valid_s;
    logic        bus_cycle_s;
    logic        bus_wr_s;
    logic        wr_word0_s;
    logic        eoi_s;
    logic [7:0]  eoi_mask_s;
    logic [7:0]  irr_next_s;
    logic [7:0]  isr_next_s;
    logic [15:0] rd_word_s;
    logic [7:0]  vector_next_s;

    // Request-line synchroniser and edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 8'h00;
            sync2_r <= 8'h00;
            hist_r  <= 8'h00;
        end else begin
            sync1_r <= irqs;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Priority resolution against mask and in-service bits.
    always_comb begin
        rise_s      = sync2_r & ~hist_r;
        eligible_s  = irr_r & ~imr_r;
        isr_low_s   = lowest_one(isr_r);
        // Bits strictly below the lowest in-service bit; with ISR = 0 the
        // subtraction wraps to 8'hFF and every eligible bit qualifies.
        nest_mask_s = isr_low_s - 8'd1;
        cand_s      = eligible_s & nest_mask_s;
        grant_s     = lowest_one(cand_s);
        win_valid_s = (cand_s != 8'h00);
        win_idx_s   = encode8(grant_s);
    end

    // Bus decode and read-data selection.
    always_comb begin
        bus_cycle_s = cs & data_m_access;
        bus_wr_s    = bus_cycle_s & data_m_wr_en;
        wr_word0_s  = bus_wr_s & ~data_m_addr;
        eoi_s       = bus_wr_s & data_m_addr & data_m_bytesel[0];
        if (data_m_addr) begin
            rd_word_s = {isr_r, irr_r};
        end else begin
            rd_word_s = {base_r, 3'b000, imr_r};
        end
    end

    // Next IRR/ISR: acknowledge, end-of-interrupt and new edges combined.
    always_comb begin
        irr_next_s = irr_r;
        isr_next_s = isr_r;
        // EOI targets the lowest in-service bit as seen before any acknowledge
        // in the same cycle; the granted bit is always a different bit.
        if (eoi_s) begin
            eoi_mask_s = isr_low_s;
        end else begin
            eoi_mask_s = 8'h00;
        end
        if (inta && win_valid_s) begin
            irr_next_s = irr_r & ~grant_s;
            isr_next_s = isr_r | grant_s;
        end else begin
            irr_next_s = irr_r;
            isr_next_s = isr_r;
        end
        isr_next_s = isr_next_s & ~eoi_mask_s;
        // A fresh edge is ORed in last so it survives a same-cycle clear.
        irr_next_s = irr_next_s | rise_s;
    end

    // Vector presented for this acknowledge (spurious uses index 7).
    always_comb begin
        if (win_valid_s) begin
            vector_next_s = {base_r, win_idx_s};
        end else begin
            vector_next_s = {base_r, 3'd7};
        end
    end

    // Mask and vector-base registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imr_r  <= 8'hFF;
            base_r <= 5'b00001;
        end else if (wr_word0_s) begin
            if (data_m_bytesel[0]) begin
                imr_r <= data_m_data_in[7:0];
            end
            if (data_m_bytesel[1]) begin
                base_r <= data_m_data_in[15:11];
            end
        end
    end

    // Request and in-service registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irr_r <= 8'h00;
            isr_r <= 8'h00;
        end else begin
            irr_r <= irr_next_s;
            isr_r <= isr_next_s;
        end
    end

    // CPU-side outputs: registered intr and the latched vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            intr_r   <= 1'b0;
            vector_r <= 8'h00;
        end else begin
            intr_r <= win_valid_s;
            if (inta) begin
                vector_r <= vector_next_s;
            end
        end
    end

    // Bus acknowledge and registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_r   <= 1'b0;
            rdata_r <= 16'h0000;
        end else begin
            ack_r <= bus_cycle_s;
            if (bus_cycle_s && !data_m_wr_en) begin
                rdata_r <= rd_word_s;
            end else begin
                rdata_r <= 16'h0000;
            end
        end
    end

    assign intr            = intr_r;
    assign irq_vector      = vector_r;
    assign data_m_ack      = ack_r;
    assign data_m_data_out = rdata_r;

endmodule
